dff_bank_arbiter: RTL and testbench
===================================

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the bit width of the shared D-flip-flop register.
REQ-002 SHALL have parameter HOLD, default 4, the maximum number of consecutive writes one owner may make while the other requester waits; legal range 1..15.
REQ-003 C_i  input  1  clock; all state changes on its rising edge.
REQ-004 nR_i  input  1  reset, asynchronous, active-low.
REQ-005 REQ0_i  input  1  requester 0 asks for, and holds, ownership of the register.
REQ-006 D0_i  input  WIDTH  requester 0 write data.
REQ-007 REQ1_i  input  1  requester 1 asks for, and holds, ownership of the register.
REQ-008 D1_i  input  WIDTH  requester 1 write data.
REQ-009 GNT0_o  output  1  requester 0 owns the register (registered).
REQ-010 GNT1_o  output  1  requester 1 owns the register (registered).
REQ-011 Q_o  output  WIDTH  shared register contents.
REQ-012 nQ_o  output  WIDTH  bitwise complement of Q_o.
REQ-013 BUSY_o  output  1  GNT0_o OR GNT1_o.
REQ-014 WCNT_o  output  8  total accepted writes, modulo 256.

Function
REQ-015 The FSM SHALL have the states IDLE, OWN0 and OWN1; GNT0_o SHALL be 1 only in OWN0 and GNT1_o SHALL be 1 only in OWN1, so at most one grant is ever high.
REQ-016 From IDLE, the FSM SHALL move to OWN0 if only REQ0_i is high, to OWN1 if only REQ1_i is high, to the owner opposite LAST if both are high, and SHALL stay in IDLE if neither is high.
REQ-017 A write SHALL occur on a rising edge where GNTx_o=1 and REQx_i=1: Q_o<=Dx_i, WCNT_o<=WCNT_o+1 (255 wraps to 0), and HCNT<=HCNT+1.
REQ-018 In OWNx, if REQx_i=0, the FSM SHALL go to OWN(other) when REQ(other)_i=1, otherwise to IDLE; no write SHALL occur on that edge.
REQ-019 In OWNx, if REQx_i=1 and REQ(other)_i=1 and the current edge's write brings HCNT to HOLD, the FSM SHALL go to OWN(other) after that write.
REQ-020 In OWNx, if REQx_i=1 and the other requester is idle, the FSM SHALL stay in OWNx and HCNT SHALL saturate at HOLD.
REQ-021 On every transition into OWNx, LAST SHALL be set to x and HCNT SHALL be cleared to 0.
REQ-022 OWN0 to OWN1 (and the reverse) SHALL be direct, with no IDLE cycle between them.
REQ-023 Latency: a request sampled at edge k SHALL give a grant visible after edge k; the first write SHALL be at edge k+1 if the request is still high; Q_o SHALL update directly after the write edge.
REQ-024 A requester dropping its request in the same cycle its grant rises SHALL get no write; the FSM SHALL leave that ownership on the next edge per REQ-018.
REQ-025 nQ_o SHALL equal ~Q_o at all times, including during reset.
REQ-026 Q_o SHALL change only on a write edge.

Reset
REQ-027 While nR_i=0, independent of C_i, outputs SHALL be: state=IDLE, GNT0_o=0, GNT1_o=0, BUSY_o=0, Q_o=0, nQ_o=all ones, WCNT_o=0; internally HCNT=0 and LAST=1, so requester 0 wins the first tie.
REQ-028 Reset asserted mid-ownership SHALL drop the grant immediately with no partial write; the first edge after nR_i rises SHALL be evaluated as IDLE.

Verification (WIDTH=8, HOLD=4)
REQ-029 Reset, then REQ0_i=1 with D0_i=8'hA5 held for 3 edges -> GNT0_o=1 after edge 1; Q_o=A5 and nQ_o=5A after edge 2; WCNT_o=2 after edge 3.
REQ-030 REQ0_i and REQ1_i rise together from reset, with D0=11 and D1=22, and both held -> GNT0 for 4 writes (Q=11), then GNT1 with no gap; GNT1 makes 4 writes (Q=22); ownership then returns to GNT0.
REQ-031 REQ1_i alone held for 10 edges -> GNT1 stays high (no forced handoff); WCNT_o=9.
REQ-032 Owner 0 drops REQ0_i while REQ1_i=1 -> GNT0 falls and GNT1 rises on the same edge, with no write on that edge.
REQ-033 WCNT_o preloaded to 255 by 255 writes, then one more write -> WCNT_o=0.
REQ-034 nR_i pulsed low between clock edges during OWN1 with Q=3C -> GNT1_o=0, Q_o=00 and nQ_o=FF immediately; after release, REQ0 and REQ1 both high -> GNT0 is granted.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// Shared WIDTH-bit register with a two-requester arbiter: the requester that
// holds the grant writes it, with fair handoff after HOLD consecutive writes.
module dff_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             C_i,
    input  logic             nR_i,
    input  logic             REQ0_i,
    input  logic [WIDTH-1:0] D0_i,
    input  logic             REQ1_i,
    input  logic [WIDTH-1:0] D1_i,
    output logic             GNT0_o,
    output logic             GNT1_o,
    output logic [WIDTH-1:0] Q_o,
    output logic [WIDTH-1:0] nQ_o,
    output logic             BUSY_o,
    output logic [7:0]       WCNT_o
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    localparam logic [4:0] HOLD_W = 5'(HOLD);
    localparam logic [3:0] HOLD_S = 4'(HOLD);

    state_t     state;
    logic       last;
    logic [3:0] hcnt;
    logic [4:0] hcnt_inc;
    logic       hold_done;
    logic [3:0] hcnt_sat;

    // One bit wider so a saturated count plus one still compares correctly.
    assign hcnt_inc  = {1'b0, hcnt} + 5'd1;
    assign hold_done = (hcnt_inc >= HOLD_W);
    assign hcnt_sat  = hold_done ? HOLD_S : hcnt_inc[3:0];

    assign nQ_o   = ~Q_o;
    assign BUSY_o = GNT0_o | GNT1_o;

    // NOTE: all state below is updated with <= so every register samples
    // the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge C_i or negedge nR_i) begin
        if (!nR_i) begin
            state  <= IDLE;
            GNT0_o <= 1'b0;
            GNT1_o <= 1'b0;
            Q_o    <= '0;
            WCNT_o <= 8'd0;
            hcnt   <= 4'd0;
            last   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the requester that did not own last wins.
                    if (REQ0_i && (!REQ1_i || last)) begin
                        state  <= OWN0;
                        GNT0_o <= 1'b1;
                        last   <= 1'b0;
                        hcnt   <= 4'd0;
                    end else if (REQ1_i) begin
                        state  <= OWN1;
                        GNT1_o <= 1'b1;
                        last   <= 1'b1;
                        hcnt   <= 4'd0;
                    end
                end

                OWN0: begin
                    if (!REQ0_i) begin
                        GNT0_o <= 1'b0;
                        if (REQ1_i) begin
                            state  <= OWN1;
                            GNT1_o <= 1'b1;
                            last   <= 1'b1;
                            hcnt   <= 4'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        Q_o    <= D0_i;
                        WCNT_o <= WCNT_o + 8'd1;
                        if (REQ1_i && hold_done) begin
                            state  <= OWN1;
                            GNT0_o <= 1'b0;
                            GNT1_o <= 1'b1;
                            last   <= 1'b1;
                            hcnt   <= 4'd0;
                        end else begin
                            hcnt <= hcnt_sat;
                        end
                    end
                end

                OWN1: begin
                    if (!REQ1_i) begin
                        GNT1_o <= 1'b0;
                        if (REQ0_i) begin
                            state  <= OWN0;
                            GNT0_o <= 1'b1;
                            last   <= 1'b0;
                            hcnt   <= 4'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        Q_o    <= D1_i;
                        WCNT_o <= WCNT_o + 8'd1;
                        if (REQ0_i && hold_done) begin
                            state  <= OWN0;
                            GNT1_o <= 1'b0;
                            GNT0_o <= 1'b1;
                            last   <= 1'b0;
                            hcnt   <= 4'd0;
                        end else begin
                            hcnt <= hcnt_sat;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    GNT0_o <= 1'b0;
                    GNT1_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (WIDTH=8, HOLD=4).
module tb_dff_bank_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       gnt0;
    logic       gnt1;
    logic [7:0] q;
    logic [7:0] nq;
    logic       busy;
    logic [7:0] wcnt;

    int checks = 0;
    int errors = 0;

    dff_bank_arbiter #(.WIDTH(8), .HOLD(4)) dut (
        .C_i    (clk),
        .nR_i   (rst_n),
        .REQ0_i (req0),
        .D0_i   (d0),
        .REQ1_i (req1),
        .D1_i   (d1),
        .GNT0_o (gnt0),
        .GNT1_o (gnt1),
        .Q_o    (q),
        .nQ_o   (nq),
        .BUSY_o (busy),
        .WCNT_o (wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b0;
        d0    = 8'hFF;
        d1    = 8'h00;

        // Reset held across edges with a live request: nothing may move.
        tick();
        tick();
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_q",    q,    8'h00);
        check("rst_nq",   nq,   8'hFF);
        check("rst_wcnt", wcnt, 8'd0);

        // Single requester: grant, then writes.
        @(negedge clk);
        rst_n = 1'b1;
        req0  = 1'b1;
        d0    = 8'hA5;
        tick();
        check("s1_gnt0_e1", gnt0, 1'b1);
        check("s1_busy_e1", busy, 1'b1);
        check("s1_q_e1",    q,    8'h00);
        tick();
        check("s1_q_e2",    q,    8'hA5);
        check("s1_nq_e2",   nq,   8'h5A);
        check("s1_wcnt_e2", wcnt, 8'd1);
        tick();
        check("s1_wcnt_e3", wcnt, 8'd2);
        req0 = 1'b0;
        d0   = 8'h00;
        tick();
        check("s1_idle_gnt0", gnt0, 1'b0);
        check("s1_idle_busy", busy, 1'b0);
        check("s1_q_hold",    q,    8'hA5);
        check("s1_wcnt_hold", wcnt, 8'd2);

        // Simultaneous requests from reset: requester 0 first, HOLD=4 each.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        d0   = 8'h11;
        d1   = 8'h22;
        tick();
        check("tie_first_gnt0", gnt0, 1'b1);
        check("tie_first_gnt1", gnt1, 1'b0);
        repeat (3) tick();
        check("tie_own0_3w_gnt0", gnt0, 1'b1);
        check("tie_own0_3w_q",    q,    8'h11);
        tick();
        check("tie_hand01_gnt0", gnt0, 1'b0);
        check("tie_hand01_gnt1", gnt1, 1'b1);
        check("tie_hand01_q",    q,    8'h11);
        check("tie_hand01_wcnt", wcnt, 8'd4);
        repeat (3) tick();
        check("tie_own1_3w_gnt1", gnt1, 1'b1);
        check("tie_own1_3w_q",    q,    8'h22);
        tick();
        check("tie_hand10_gnt0", gnt0, 1'b1);
        check("tie_hand10_gnt1", gnt1, 1'b0);
        check("tie_hand10_wcnt", wcnt, 8'd8);

        // Lone requester 1 keeps ownership indefinitely.
        do_reset();
        req1 = 1'b1;
        d1   = 8'h66;
        repeat (10) tick();
        check("solo1_gnt1", gnt1, 1'b1);
        check("solo1_gnt0", gnt0, 1'b0);
        check("solo1_wcnt", wcnt, 8'd9);
        check("solo1_q",    q,    8'h66);

        // Requester 0 arrives after saturation: handoff after one more write.
        req0 = 1'b1;
        d0   = 8'h77;
        tick();
        check("late0_gnt0", gnt0, 1'b1);
        check("late0_gnt1", gnt1, 1'b0);
        check("late0_wcnt", wcnt, 8'd10);
        tick();
        check("late0_q",    q,    8'h77);
        check("late0_wcnt2", wcnt, 8'd11);

        // Owner 0 drops with requester 1 waiting: direct switch, no write.
        req0 = 1'b0;
        d0   = 8'h99;
        tick();
        check("drop0_gnt0", gnt0, 1'b0);
        check("drop0_gnt1", gnt1, 1'b1);
        check("drop0_busy", busy, 1'b1);
        check("drop0_q",    q,    8'h77);
        check("drop0_wcnt", wcnt, 8'd11);

        // Asynchronous reset pulse while owner 1 holds Q=3C.
        d1 = 8'h3C;
        tick();
        check("pre_rst_q",    q,    8'h3C);
        check("pre_rst_gnt1", gnt1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt1", gnt1, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_q",    q,    8'h00);
        check("arst_nq",   nq,   8'hFF);
        check("arst_wcnt", wcnt, 8'd0);
        #1;
        rst_n = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        tick();
        check("post_rst_gnt0", gnt0, 1'b1);
        check("post_rst_gnt1", gnt1, 1'b0);
        check("post_rst_q",    q,    8'h00);

        // Write counter wraps from 255 to 0.
        do_reset();
        req0 = 1'b1;
        d0   = 8'hC3;
        tick();
        repeat (255) tick();
        check("wrap_wcnt_255", wcnt, 8'd255);
        check("wrap_q",        q,    8'hC3);
        tick();
        check("wrap_wcnt_0",   wcnt, 8'd0);
        check("wrap_gnt0",     gnt0, 1'b1);

        // Grant rises while the request has already dropped: no write.
        do_reset();
        req1 = 1'b1;
        d1   = 8'hEE;
        tick();
        req1 = 1'b0;
        check("blip_gnt1", gnt1, 1'b1);
        tick();
        check("blip_idle", busy, 1'b0);
        check("blip_q",    q,    8'h00);
        check("blip_wcnt", wcnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
